kan_output_capture: RTL and testbench

- Receiving end of the KAN datapath: accepts 16-bit inference results over a valid/ready stream and buffers a programmed number of them.
- Keeps running sum/min/max statistics on captured samples.
- Replays the buffered samples in order through a registered read port for host or bench readback.
- Sits between the KAN core output and the debug/readback logic.

---
 rtl/kan_output_capture.sv | 189 ++++++++++++++++++
 tb/tb_kan_output_capture.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/kan_output_capture.sv
// kan_output_capture
//
// Receiving end of the KAN datapath. A start pulse arms a capture of
// eff_len samples (target_len, or DEPTH when target_len is 0 or too large).
// Accepted samples go into a small buffer while running sum/min/max
// statistics are kept. Once the run is complete the buffer is replayed,
// oldest first, through a registered read port.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous active-low reset
//   start      one-cycle pulse: arm (or abort and re-arm) a capture
//   target_len requested sample count (0 or >DEPTH selects DEPTH)
//   in_valid   / in_data / in_ready   sample input stream
//   rd_req     request the next buffered sample
//   rd_valid   / rd_data              read result, one cycle after rd_req
//   count      samples captured in the current run
//   done       capture complete, buffer readable
//   stat_sum   unsigned, wrapping sum of captured samples
//   stat_min   minimum captured sample (all ones when none captured)
//   stat_max   maximum captured sample
//   rd_err     sticky: rd_req seen with nothing to read
module kan_output_capture #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [CNT_W-1:0]            target_len,
    input  logic                        in_valid,
    input  logic [DATA_WIDTH-1:0]       in_data,
    output logic                        in_ready,
    input  logic                        rd_req,
    output logic                        rd_valid,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic [CNT_W-1:0]            count,
    output logic                        done,
    output logic [DATA_WIDTH+CNT_W-1:0] stat_sum,
    output logic [DATA_WIDTH-1:0]       stat_min,
    output logic [DATA_WIDTH-1:0]       stat_max,
    output logic                        rd_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [DATA_WIDTH-1:0]       buf_mem [DEPTH];
    logic [PTR_W-1:0]            wr_ptr_reg;
    logic [PTR_W-1:0]            rd_ptr_reg;
    logic [CNT_W-1:0]            count_reg;
    logic [CNT_W-1:0]            rd_cnt_reg;
    logic [CNT_W-1:0]            eff_len_reg;
    logic [CNT_W-1:0]            eff_len_next;
    logic                        rd_valid_reg;
    logic [DATA_WIDTH-1:0]       rd_data_reg;
    logic                        done_reg;
    logic                        rd_err_reg;
    logic [DATA_WIDTH+CNT_W-1:0] sum_reg;
    logic [DATA_WIDTH-1:0]       min_reg;
    logic [DATA_WIDTH-1:0]       max_reg;

    logic accept;
    logic rd_fire;
    logic last_accept;
    logic last_read;

    // Next-state and datapath strobes. start has priority over both an
    // accepted sample and a read in the same cycle.
    always_comb begin
        state_next   = state_reg;
        accept       = 1'b0;
        rd_fire      = 1'b0;
        last_accept  = 1'b0;
        last_read    = 1'b0;
        eff_len_next = ((target_len == '0) || (target_len > DEPTH_C)) ? DEPTH_C : target_len;

        if (start) begin
            state_next = ST_CAPTURE;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    state_next = ST_IDLE;
                end
                ST_CAPTURE: begin
                    accept      = in_valid;
                    last_accept = in_valid && ((count_reg + ONE_C) == eff_len_reg);
                    if (last_accept) begin
                        state_next = ST_DONE;
                    end
                end
                ST_DONE: begin
                    rd_fire   = rd_req && (rd_cnt_reg < count_reg);
                    last_read = rd_fire && ((rd_cnt_reg + ONE_C) == count_reg);
                    if (last_read) begin
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            rd_cnt_reg   <= '0;
            eff_len_reg  <= DEPTH_C;
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
            done_reg     <= 1'b0;
            rd_err_reg   <= 1'b0;
            sum_reg      <= '0;
            min_reg      <= '1;
            max_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            rd_valid_reg <= rd_fire;
            // done stays up through the edge of the final read so it drops
            // one cycle after the last rd_valid is presented.
            done_reg     <= !start && ((state_next == ST_DONE) || last_read);

            if (start) begin
                eff_len_reg <= eff_len_next;
                wr_ptr_reg  <= '0;
                rd_ptr_reg  <= '0;
                count_reg   <= '0;
                rd_cnt_reg  <= '0;
                rd_err_reg  <= 1'b0;
                sum_reg     <= '0;
                min_reg     <= '1;
                max_reg     <= '0;
            end else begin
                if (rd_req && !rd_fire) begin
                    rd_err_reg <= 1'b1;
                end
                if (accept) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    count_reg  <= count_reg + ONE_C;
                    sum_reg    <= sum_reg + {{CNT_W{1'b0}}, in_data};
                    if (in_data < min_reg) begin
                        min_reg <= in_data;
                    end
                    if (in_data > max_reg) begin
                        max_reg <= in_data;
                    end
                end
                if (rd_fire) begin
                    rd_ptr_reg  <= rd_ptr_reg + 1'b1;
                    rd_cnt_reg  <= rd_cnt_reg + ONE_C;
                    rd_data_reg <= buf_mem[rd_ptr_reg];
                end
            end
        end
    end

    // Buffer storage kept free of reset so it maps onto block RAM; accept is
    // already qualified by start, and reset masks the write here.
    always_ff @(posedge clk) begin
        if (reset && accept) begin
            buf_mem[wr_ptr_reg] <= in_data;
        end
    end

    assign in_ready = (state_reg == ST_CAPTURE);
    assign rd_valid = rd_valid_reg;
    assign rd_data  = rd_data_reg;
    assign count    = count_reg;
    assign done     = done_reg;
    assign stat_sum = sum_reg;
    assign stat_min = min_reg;
    assign stat_max = max_reg;
    assign rd_err   = rd_err_reg;

endmodule

// File: tb/tb_kan_output_capture.sv
module tb_kan_output_capture;
    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [CW-1:0]   target_len;
    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic            in_ready;
    logic            rd_req;
    logic            rd_valid;
    logic [DW-1:0]   rd_data;
    logic [CW-1:0]   count;
    logic            done;
    logic [DW+CW-1:0] stat_sum;
    logic [DW-1:0]   stat_min;
    logic [DW-1:0]   stat_max;
    logic            rd_err;

    kan_output_capture #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .target_len(target_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
        .count(count), .done(done), .stat_sum(stat_sum),
        .stat_min(stat_min), .stat_max(stat_max), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: what has been captured, and what may still be read.
    int unsigned q[$];
    int unsigned m_eff;
    bit          m_cap;      // accepting samples
    bit          m_readable; // capture complete, unread data remains
    int          m_rd_idx;
    bit          m_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned m_sum();
        longint unsigned s = 0;
        foreach (q[i]) s += q[i];
        return s % (64'd1 << (DW + CW));
    endfunction

    function automatic int unsigned m_min();
        int unsigned v = (1 << DW) - 1;
        foreach (q[i]) if (q[i] < v) v = q[i];
        return v;
    endfunction

    function automatic int unsigned m_max();
        int unsigned v = 0;
        foreach (q[i]) if (q[i] > v) v = q[i];
        return v;
    endfunction

    task automatic check_stats(input string tag);
        check({tag, ".count"}, 64'(count), 64'(q.size()));
        check({tag, ".sum"}, 64'(stat_sum), m_sum());
        check({tag, ".min"}, 64'(stat_min), 64'(m_min()));
        check({tag, ".max"}, 64'(stat_max), 64'(m_max()));
        check({tag, ".done"}, 64'(done), 64'(m_readable));
    endtask

    task automatic model_clear();
        q.delete();
        m_cap = 0; m_readable = 0; m_rd_idx = 0; m_err = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; rd_req = 1'b0;
        tick();
        model_clear();
        reset = 1'b1;
    endtask

    // Arm a capture; the sample on in_data (if any) must not be captured.
    task automatic do_start(input int len, input bit with_valid, input int unsigned data);
        start = 1'b1; target_len = CW'(len); in_valid = with_valid; in_data = DW'(data);
        tick();
        start = 1'b0; in_valid = 1'b0;
        model_clear();
        m_eff = (len == 0 || len > DEPTH) ? DEPTH : len;
        m_cap = 1;
        $display("[TB] start len=%0d eff=%0d", len, m_eff);
        check("start.rd_err", 64'(rd_err), 0);
        check("start.count", 64'(count), 0);
        check("start.rd_valid", 64'(rd_valid), 0);
    endtask

    task automatic push_cycle(input bit v, input int unsigned data);
        bit acc;
        check("in_ready", 64'(in_ready), 64'(m_cap));
        acc = v && m_cap;
        in_valid = v; in_data = DW'(data);
        tick();
        in_valid = 1'b0;
        if (acc) begin
            q.push_back(data);
            if (q.size() == m_eff) begin
                m_cap = 0; m_readable = 1;
            end
        end
        if (v) $display("[TB] push %0d accepted=%0d", data, acc);
        check("push.count", 64'(count), 64'(q.size()));
    endtask

    task automatic read_cycle(input bit r);
        bit exp_v;
        exp_v = r && m_readable && (m_rd_idx < q.size());
        if (r && !exp_v) m_err = 1;
        rd_req = r;
        tick();
        rd_req = 1'b0;
        check("rd_valid", 64'(rd_valid), 64'(exp_v));
        if (exp_v) begin
            check("rd_data", 64'(rd_data), 64'(q[m_rd_idx]));
            $display("[TB] read idx=%0d data=%0d", m_rd_idx, rd_data);
            m_rd_idx++;
            if (m_rd_idx == q.size()) m_readable = 0;
        end else if (r) begin
            $display("[TB] read refused");
        end
        check("rd_err", 64'(rd_err), 64'(m_err));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".in_ready"}, 64'(in_ready), 0);
        check({tag, ".rd_valid"}, 64'(rd_valid), 0);
        check({tag, ".rd_data"}, 64'(rd_data), 0);
        check({tag, ".rd_err"}, 64'(rd_err), 0);
        check_stats(tag);
    endtask

    initial begin
        int sample_list[5] = '{50, 100, 150, 75, 175};
        int budget;

        target_len = '0; in_data = '0;
        do_reset();
        do_reset();
        check_reset_state("reset");

        // Directed capture of five samples with in_valid held high.
        do_start(5, 0, 0);
        foreach (sample_list[i]) push_cycle(1, sample_list[i]);
        push_cycle(1, 999);
        check_stats("t1");
        check("t1.sum_abs", 64'(stat_sum), 550);

        // Drain with rd_req held, then a surplus read.
        for (int i = 0; i < 5; i++) read_cycle(1);
        tick();
        check("t2.done_low", 64'(done), 0);
        check("t2.rd_err", 64'(rd_err), 0);
        read_cycle(1);
        check("t4.err_set", 64'(rd_err), 1);

        // target_len 0 selects DEPTH; ninth sample refused.
        do_start(0, 0, 0);
        check("t4.err_clear", 64'(rd_err), 0);
        for (int i = 1; i <= 9; i++) push_cycle(1, i);
        check_stats("t3");
        check("t3.sum_abs", 64'(stat_sum), 36);

        // rd_req before the run is done.
        do_start(3, 0, 0);
        read_cycle(1);

        // Restart mid-capture, colliding with a valid sample.
        do_start(4, 0, 0);
        push_cycle(1, 300);
        push_cycle(1, 200);
        do_start(2, 1, 999);
        check("t5.count", 64'(count), 0);
        push_cycle(1, 7);
        push_cycle(1, 9);
        check_stats("t5");
        check("t5.sum_abs", 64'(stat_sum), 16);

        // Reset mid-drain.
        do_start(3, 0, 0);
        for (int i = 0; i < 3; i++) push_cycle(1, 40 + i);
        read_cycle(1);
        rd_req = 1'b1;
        do_reset();
        check_reset_state("t6");
        read_cycle(1);

        // Randomised runs with gaps on both streams.
        for (int run = 0; run < 6; run++) begin
            do_start($urandom_range(0, 15), 0, 0);
            budget = 200;
            while (m_cap && budget > 0) begin
                push_cycle($urandom_range(0, 2) != 0, $urandom_range(0, 65535));
                budget--;
            end
            if (m_cap) begin
                tests++; fails++;
                $error("FAIL rand.capture_timeout: observed count %0d expected %0d", count, m_eff);
            end
            check_stats("rand");
            budget = 200;
            while (m_readable && budget > 0) begin
                read_cycle($urandom_range(0, 2) != 0);
                budget--;
            end
            if (m_readable) begin
                tests++; fails++;
                $error("FAIL rand.drain_timeout: observed idx %0d expected %0d", m_rd_idx, q.size());
            end
            tick();
            check("rand.done_low", 64'(done), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
